// File: rtl/window_3x3_linebuf_if.sv
// Pixel-stream / window bus for the 3x3 line-buffer stage.
// Optional FRAME_DONE_EN adds the frame_done strobe.
interface window_3x3_linebuf_if #(
  parameter int unsigned n     = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [n-1:0]  pix_in;
  logic          pix_valid;
  logic [n-1:0]  w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic          win_valid;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;
`ifdef FRAME_DONE_EN
  logic          frame_done;

  modport master (
    output pix_in, pix_valid,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, col_idx, row_idx, frame_done
  );
  modport slave (
    input  pix_in, pix_valid,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, col_idx, row_idx, frame_done
  );
`else
  modport master (
    output pix_in, pix_valid,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, col_idx, row_idx
  );
  modport slave (
    input  pix_in, pix_valid,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9, win_valid, col_idx, row_idx
  );
`endif
endinterface

// File: rtl/window_3x3_linebuf.sv
// Two-row line buffer producing registered interior 3x3 windows from a raster stream.
// Optional FRAME_DONE_EN adds a frame_done pulse on the last pixel of each frame.
module window_3x3_linebuf #(
  parameter int unsigned n     = 8,
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input logic                  clk,
  input logic                  reset,
  window_3x3_linebuf_if.slave  bus
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          last_col;
  logic          last_row;

  // lb*[IMG_W-1] is the oldest entry: exactly one row behind the input
  logic [IMG_W-1:0][n-1:0] lb1;
  logic [IMG_W-1:0][n-1:0] lb2;

  assign accept      = bus.pix_valid && !reset;
  assign last_col    = (col == CW'(IMG_W - 1));
  assign last_row    = (row == RW'(IMG_H - 1));
  assign bus.col_idx = col;
  assign bus.row_idx = row;

  // Contents are never cleared; win_valid gating hides stale rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1 <= {lb1[IMG_W-2:0], bus.pix_in};
      lb2 <= {lb2[IMG_W-2:0], lb1[IMG_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col           <= '0;
      row           <= '0;
      bus.w1        <= '0;
      bus.w2        <= '0;
      bus.w3        <= '0;
      bus.w4        <= '0;
      bus.w5        <= '0;
      bus.w6        <= '0;
      bus.w7        <= '0;
      bus.w8        <= '0;
      bus.w9        <= '0;
      bus.win_valid <= 1'b0;
    end else begin
      bus.win_valid <= 1'b0;
      if (bus.pix_valid) begin
        bus.w1 <= bus.w2;
        bus.w2 <= bus.w3;
        bus.w3 <= lb2[IMG_W-1];
        bus.w4 <= bus.w5;
        bus.w5 <= bus.w6;
        bus.w6 <= lb1[IMG_W-1];
        bus.w7 <= bus.w8;
        bus.w8 <= bus.w9;
        bus.w9 <= bus.pix_in;
        bus.win_valid <= (row >= RW'(2)) && (col >= CW'(2));
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef FRAME_DONE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= bus.pix_valid && last_col && last_row;
    end
  end
`endif

endmodule
